// File: rtl/scoreboard_pkg.sv
// Shared types and BCD helpers for the two-player score keeper.
// Scores are held as packed two-digit BCD {tens, ones}.
package scoreboard_pkg;

  localparam int unsigned DigitW = 4;

  typedef enum logic [1:0] {
    LastNone = 2'b00,
    LastP1   = 2'b01,
    LastP2   = 2'b10
  } last_e;

  typedef logic [2*DigitW-1:0] bcd_t;

  function automatic bcd_t to_bcd(int unsigned v);
    return {DigitW'(v / 10), DigitW'(v % 10)};
  endfunction

  // Saturates at max_s; ones digit wraps 9 -> 0 with a carry into tens.
  function automatic bcd_t bcd_inc(bcd_t s, bcd_t max_s);
    bcd_t r;
    r = s;
    if (s != max_s) begin
      if (s[DigitW-1:0] >= DigitW'(9)) begin
        r[DigitW-1:0]        = '0;
        r[2*DigitW-1:DigitW] = s[2*DigitW-1:DigitW] + DigitW'(1);
      end else begin
        r[DigitW-1:0] = s[DigitW-1:0] + DigitW'(1);
      end
    end
    return r;
  endfunction

  // Floors at 00; ones digit wraps 0 -> 9 with a borrow from tens.
  function automatic bcd_t bcd_dec(bcd_t s);
    bcd_t r;
    r = s;
    if (s != '0) begin
      if (s[DigitW-1:0] == '0) begin
        r[DigitW-1:0]        = DigitW'(9);
        r[2*DigitW-1:DigitW] = s[2*DigitW-1:DigitW] - DigitW'(1);
      end else begin
        r[DigitW-1:0] = s[DigitW-1:0] - DigitW'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-flop synchronizer, stable-count debouncer and
// a single-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any sample matching the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign pulse_o = level_q & ~prev_q;

endmodule

// File: rtl/score_keeper.sv
// Two-player BCD score keeper with saturation and a single level of undo
// for the most recent single-player increment.
module score_keeper
  import scoreboard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned MAX_SCORE       = 99
) (
  input  logic              clk_1khz,
  input  logic              rst_ni,
  input  logic              p1_btn_i,
  input  logic              p2_btn_i,
  input  logic              undo_btn_i,
  output logic [DigitW-1:0] p1_tens_o,
  output logic [DigitW-1:0] p1_ones_o,
  output logic [DigitW-1:0] p2_tens_o,
  output logic [DigitW-1:0] p2_ones_o,
  output logic [1:0]        last_o
);

  localparam bcd_t MaxBcd = to_bcd(MAX_SCORE);

  logic  p1_ev, p2_ev, undo_ev;
  bcd_t  p1_q, p1_d, p2_q, p2_d;
  last_e last_q, last_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_p1_db (
    .clk_i  (clk_1khz),
    .rst_ni (rst_ni),
    .btn_i  (p1_btn_i),
    .pulse_o(p1_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_p2_db (
    .clk_i  (clk_1khz),
    .rst_ni (rst_ni),
    .btn_i  (p2_btn_i),
    .pulse_o(p2_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_undo_db (
    .clk_i  (clk_1khz),
    .rst_ni (rst_ni),
    .btn_i  (undo_btn_i),
    .pulse_o(undo_ev)
  );

  // Increments take priority; undo only acts on a quiet cycle.
  always_comb begin
    p1_d   = p1_q;
    p2_d   = p2_q;
    last_d = last_q;
    if (p1_ev || p2_ev) begin
      if (p1_ev) p1_d = bcd_inc(p1_q, MaxBcd);
      if (p2_ev) p2_d = bcd_inc(p2_q, MaxBcd);
      if (p1_ev && p2_ev) begin
        last_d = LastNone;
      end else if (p1_ev) begin
        last_d = LastP1;
      end else begin
        last_d = LastP2;
      end
    end else if (undo_ev) begin
      case (last_q)
        LastP1:  p1_d = bcd_dec(p1_q);
        LastP2:  p2_d = bcd_dec(p2_q);
        default: ;
      endcase
      last_d = LastNone;
    end
  end

  always_ff @(posedge clk_1khz or negedge rst_ni) begin
    if (!rst_ni) begin
      p1_q   <= '0;
      p2_q   <= '0;
      last_q <= LastNone;
    end else begin
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      last_q <= last_d;
    end
  end

  assign p1_tens_o = p1_q[2*DigitW-1:DigitW];
  assign p1_ones_o = p1_q[DigitW-1:0];
  assign p2_tens_o = p2_q[2*DigitW-1:DigitW];
  assign p2_ones_o = p2_q[DigitW-1:0];
  assign last_o    = last_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes timed expectations from an
// integer score model; a negedge monitor pops and compares them.
module tb_score_keeper;

  localparam int N    = 4;
  localparam int MaxS = 99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       p1 = 1'b0, p2 = 1'b0, ub = 1'b0;
  logic [3:0] p1t, p1o, p2t, p2o;
  logic [1:0] last;
  logic [17:0] dut_vec;

  score_keeper #(.DEBOUNCE_CYCLES(N), .MAX_SCORE(MaxS)) dut (
    .clk_1khz  (clk),
    .rst_ni    (rst_n),
    .p1_btn_i  (p1),
    .p2_btn_i  (p2),
    .undo_btn_i(ub),
    .p1_tens_o (p1t),
    .p1_ones_o (p1o),
    .p2_tens_o (p2t),
    .p2_ones_o (p2o),
    .last_o    (last)
  );

  always #5 clk = ~clk;
  assign dut_vec = {p1t, p1o, p2t, p2o, last};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [17:0] exp;
    string       name;
  } chk_t;
  chk_t q[$];

  int n_vec = 0, n_bad = 0;
  int m_p1 = 0, m_p2 = 0, m_last = 0;

  function automatic logic [17:0] model_vec();
    return {4'(m_p1 / 10), 4'(m_p1 % 10), 4'(m_p2 / 10), 4'(m_p2 % 10), 2'(m_last)};
  endfunction

  // Score rules in plain integer arithmetic.
  task automatic model_event(input bit e1, input bit e2, input bit eu);
    if (e1 || e2) begin
      if (e1 && m_p1 < MaxS) m_p1++;
      if (e2 && m_p2 < MaxS) m_p2++;
      m_last = (e1 && e2) ? 0 : (e1 ? 1 : 2);
    end else if (eu && m_last != 0) begin
      if (m_last == 1 && m_p1 > 0) m_p1--;
      if (m_last == 2 && m_p2 > 0) m_p2--;
      m_last = 0;
    end
  endtask

  task automatic compare(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got p1=%0d%0d p2=%0d%0d last=%b, want p1=%0d%0d p2=%0d%0d last=%b",
               name, act[17:14], act[13:10], act[9:6], act[5:2], act[1:0],
               exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1:0]);
    end
  endtask

  task automatic expect_at(input int at, input string name);
    chk_t e;
    e.cyc  = at;
    e.exp  = model_vec();
    e.name = name;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    chk_t c;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      c = q.pop_front();
      compare(c.name, dut_vec, c.exp);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; edge 1 is the next posedge, so the update lands on edge N+3.
  task automatic press(input bit b1, input bit b2, input bit bu, input int hold,
                       input string name);
    int c;
    c = cyc;
    expect_at(c + 2 + N, {name, " pre"});
    model_event(b1, b2, bu);
    expect_at(c + 3 + N, {name, " post"});
    p1 = b1;
    p2 = b2;
    ub = bu;
    step(hold);
    p1 = 1'b0;
    p2 = 1'b0;
    ub = 1'b0;
    step(N + 5);
    expect_at(cyc + 1, {name, " settle"});
    step(2);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    p1 = 1'b0;
    p2 = 1'b0;
    ub = 1'b0;
    rst_n = 1'b0;
    m_p1 = 0;
    m_p2 = 0;
    m_last = 0;
    #1;
    compare(name, dut_vec, model_vec());
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic set_scores(input int a, input int b);
    do_reset("reset before preload");
    for (int i = 0; i < a; i++) press(1, 0, 0, N + 2, "preload p1");
    for (int i = 0; i < b; i++) press(0, 1, 0, N + 2, "preload p2");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int kind;
    step(1);
    do_reset("initial reset");
    step(2);

    press(1, 0, 0, 20, "single p1");

    for (int i = 0; i < 9; i++) press(0, 1, 0, N + 2, "p2 to 9");
    for (int i = 0; i < 6; i++) begin
      p2 = ~p2;
      step(2);
    end
    p2 = 1'b0;
    step(2);
    c = cyc;
    expect_at(c + 2 + N, "bounce pre");
    model_event(0, 1, 0);
    expect_at(c + 3 + N, "bounce post");
    p2 = 1'b1;
    step(10);
    p2 = 1'b0;
    step(N + 5);
    expect_at(cyc + 1, "bounce settle");
    step(2);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 5));
      press(kind == 0 || kind == 2 || kind == 4, kind == 1 || kind == 2 || kind == 5,
            kind >= 3, int'($urandom_range(N + 2, N + 8)), "random");
    end

    set_scores(99, 0);
    press(1, 0, 0, N + 3, "saturated p1");
    press(0, 0, 1, N + 3, "undo after saturation");
    press(0, 0, 1, N + 3, "second undo");

    set_scores(12, 7);
    press(1, 1, 0, N + 3, "simultaneous");
    press(0, 0, 1, N + 3, "undo after simultaneous");

    press(1, 0, 0, N + 3, "p1 before undo+p2");
    press(0, 1, 1, N + 3, "undo with p2");

    // Reset mid-debounce, button released while reset is held.
    set_scores(45, 0);
    p1 = 1'b1;
    step(3);
    #2;
    rst_n = 1'b0;
    m_p1 = 0;
    m_p2 = 0;
    m_last = 0;
    #1;
    compare("mid-debounce reset", dut_vec, model_vec());
    step(3);
    p1 = 1'b0;
    rst_n = 1'b1;
    step(N + 6);
    expect_at(cyc + 1, "no stray after reset");
    step(2);

    // Button held through reset release yields exactly one event.
    p2 = 1'b1;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    compare("reset with p2 held", dut_vec, model_vec());
    step(3);
    rst_n = 1'b1;
    c = cyc;
    expect_at(c + 2 + N, "held through reset pre");
    model_event(0, 1, 0);
    expect_at(c + 3 + N, "held through reset post");
    step(N + 8);
    p2 = 1'b0;
    step(N + 5);
    expect_at(cyc + 1, "held through reset settle");
    step(4);

    while (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL pending %s: check at cycle %0d never made, now %0d", q[0].name, q[0].cyc,
               cyc);
      void'(q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
